// File: rtl/hdng_err_gen_if.sv
// Heading-error bus: gyro/desired heading samples and control in,
// saturated error with strobe and sequencer status out.
interface hdng_err_gen_if;
  logic signed [11:0] heading;
  logic               hdng_vld;
  logic signed [11:0] dsrd_hdng;
  logic               go;
  logic               clr;
  logic signed [9:0]  err_sat;
  logic               err_vld;
  logic               moving;
  logic               settled;

  modport master (
    output heading, hdng_vld, dsrd_hdng, go, clr,
    input  err_sat, err_vld, moving, settled
  );

  modport slave (
    input  heading, hdng_vld, dsrd_hdng, go, clr,
    output err_sat, err_vld, moving, settled
  );
endinterface

// File: rtl/hdng_err_gen.sv
// Two-stage heading-error producer: wrapped difference, 10-bit saturation,
// soft-start clamp ramp and a settled detector for the motion sequencer.
module hdng_err_gen #(
  parameter int RAMP_STEP  = 32,
  parameter int SETTLE_THR = 16,
  parameter int SETTLE_CNT = 8
) (
  input logic           clk,
  input logic           rst_n,
  hdng_err_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RAMP, TRACK} state_t;

  state_t             state, state_nxt;
  logic               s1_vld;
  logic signed [11:0] s1_diff;
  logic [8:0]         clamp;
  logic [10:0]        clamp_sum;
  logic [8:0]         clamp_nxt;
  logic [7:0]         cnt;
  logic               settled_q;
  logic signed [9:0]  err_sat_q;
  logic               err_vld_q;
  logic               upd;
  logic signed [11:0] lim;
  logic signed [11:0] sat12;
  logic [11:0]        mag;
  logic               in_band;

  // A go or clr arriving with the stage-2 edge wins over the sample.
  always_comb begin
    upd       = s1_vld & ~bus.clr & ~bus.go;
    clamp_sum = {2'b00, clamp} + 11'(RAMP_STEP);
    clamp_nxt = (clamp_sum >= 11'd511) ? 9'd511 : clamp_sum[8:0];
    lim       = signed'({3'b000, clamp});
    sat12     = s1_diff;
    if (sat12 > 12'sd511)
      sat12 = 12'sd511;
    else if (sat12 < -12'sd512)
      sat12 = -12'sd512;
    if (state == RAMP) begin
      if (sat12 > lim)
        sat12 = lim;
      else if (sat12 < -lim)
        sat12 = -lim;
    end
    mag     = sat12[11] ? 12'(-sat12) : 12'(sat12);
    in_band = (mag <= 12'(SETTLE_THR));
  end

  always_comb begin
    state_nxt = state;
    if (bus.clr)
      state_nxt = IDLE;
    else if (bus.go)
      state_nxt = RAMP;
    else if (upd && state == RAMP && clamp_nxt == 9'd511)
      state_nxt = TRACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Samples seen while idle never enter the pipe; clr flushes whatever is in it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_diff   <= '0;
      clamp     <= 9'(RAMP_STEP);
      cnt       <= '0;
      settled_q <= 1'b0;
      err_sat_q <= '0;
      err_vld_q <= 1'b0;
    end else begin
      err_vld_q <= 1'b0;
      s1_vld    <= bus.hdng_vld && (state != IDLE) && !bus.clr;
      if (bus.hdng_vld)
        s1_diff <= bus.heading - bus.dsrd_hdng;
      if (bus.clr) begin
        clamp     <= 9'(RAMP_STEP);
        cnt       <= '0;
        settled_q <= 1'b0;
        err_sat_q <= '0;
      end else if (bus.go) begin
        clamp     <= 9'(RAMP_STEP);
        cnt       <= '0;
        settled_q <= 1'b0;
      end else if (s1_vld) begin
        err_sat_q <= sat12[9:0];
        err_vld_q <= 1'b1;
        if (state == RAMP)
          clamp <= clamp_nxt;
        if (in_band) begin
          if ({1'b0, cnt} < 9'(SETTLE_CNT))
            cnt <= cnt + 8'd1;
          if ({1'b0, cnt} + 9'd1 >= 9'(SETTLE_CNT))
            settled_q <= 1'b1;
        end else begin
          cnt       <= '0;
          settled_q <= 1'b0;
        end
      end
    end
  end

  assign bus.err_sat = err_sat_q;
  assign bus.err_vld = err_vld_q;
  assign bus.settled = settled_q;
  assign bus.moving  = (state != IDLE);

endmodule
